// File: rtl/reg_select_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classes for the
// register-select sequencer and the ALU.
package reg_select_sequencer_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_REG_FIRST = 5'b00011;
  localparam opcode_t OP_REG_LAST  = 5'b01010;
  localparam opcode_t OP_IMM_FIRST = 5'b01011;
  localparam opcode_t OP_IMM_LAST  = 5'b01101;
  localparam opcode_t OP_NEG       = 5'b10000;
  localparam opcode_t OP_NOT       = 5'b10001;
  localparam opcode_t OP_JR        = 5'b10011;
  localparam opcode_t OP_JAL       = 5'b10100;
  localparam opcode_t OP_NOP       = 5'b11001;
  localparam opcode_t OP_HALT      = 5'b11010;

  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_REG_ALU, CLS_IMM_ALU, CLS_UNARY, CLS_JR,
    CLS_JAL, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  // Everything the stall input must silence in one bundle.
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic read;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic z_lo_out;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic illegal;
  } strobes_t;

endpackage

// File: rtl/reg_select_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/handshake inputs and the
// control strobes. master = sequencer, slave = datapath side.
interface reg_select_sequencer_if #(parameter int REG_SIZE = 32);
  logic [REG_SIZE-1:0] ir;
  logic       mem_rdy;
  logic       stall;
  logic       pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out;
  logic       read, ir_in, y_in, z_in, z_lo_out, c_out;
  logic       gra, grb, grc, r_in, r_out, ba_out;
  logic [4:0] alu_op;
  logic       run;
  logic       illegal;

  modport master (
    input  ir, mem_rdy, stall,
    output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
           read, ir_in, y_in, z_in, z_lo_out, c_out,
           gra, grb, grc, r_in, r_out, ba_out, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_rdy, stall,
    input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
           read, ir_in, y_in, z_in, z_lo_out, c_out,
           gra, grb, grc, r_in, r_out, ba_out, alu_op, run, illegal
  );
endinterface

// File: rtl/reg_select_sequencer_opcode_class_decode.sv
// Combinational opcode -> execution class lookup used to pick the T3..T5 path.
module opcode_class_decode
  import reg_select_sequencer_pkg::*;
(
  input  opcode_t   opcode,
  output op_class_t op_class
);

  always_comb begin
    if (opcode >= OP_REG_FIRST && opcode <= OP_REG_LAST)      op_class = CLS_REG_ALU;
    else if (opcode >= OP_IMM_FIRST && opcode <= OP_IMM_LAST) op_class = CLS_IMM_ALU;
    else if (opcode == OP_NEG || opcode == OP_NOT)            op_class = CLS_UNARY;
    else if (opcode == OP_JR)                                 op_class = CLS_JR;
    else if (opcode == OP_JAL)                                op_class = CLS_JAL;
    else if (opcode == OP_NOP)                                op_class = CLS_NOP;
    else if (opcode == OP_HALT)                               op_class = CLS_HALT;
    else                                                      op_class = CLS_ILLEGAL;
  end

endmodule

// File: rtl/reg_select_sequencer.sv
// Fetch/execute control FSM: strobes decode from state and the latched opcode,
// qualified only by stall; the opcode is the top five bits of ir.
module reg_select_sequencer
  import reg_select_sequencer_pkg::*;
#(
  parameter int REG_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   clr,
  reg_select_sequencer_if.master bus
);

  state_t    state_q, state_d;
  opcode_t   opcode_q, opcode_d;
  op_class_t op_class;
  strobes_t  strb;

  opcode_class_decode u_decode (
    .opcode   (opcode_q),
    .op_class (op_class)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d  = state_q;
    opcode_d = opcode_q;
    if (state_q != ST_HALT && !bus.stall) begin
      unique case (state_q)
        ST_T0: state_d = ST_T1;
        ST_T1: if (bus.mem_rdy) state_d = ST_T2;
        ST_T2: begin
          opcode_d = bus.ir[REG_SIZE-1 -: 5];
          state_d  = ST_T3;
        end
        ST_T3: begin
          unique case (op_class)
            CLS_REG_ALU, CLS_IMM_ALU, CLS_UNARY, CLS_JAL: state_d = ST_T4;
            CLS_HALT:                                     state_d = ST_HALT;
            default:                                      state_d = ST_T0;
          endcase
        end
        ST_T4: state_d = (op_class == CLS_REG_ALU || op_class == CLS_IMM_ALU) ? ST_T5 : ST_T0;
        default: state_d = ST_T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flops so every register samples
    // pre-edge values regardless of statement order.
    if (clr) begin
      state_q  <= ST_T0;
      opcode_q <= OP_NOP;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    strb = '0;
    unique case (state_q)
      ST_T0: begin
        strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.z_in = 1'b1;
      end
      ST_T1: begin
        strb.z_lo_out = 1'b1; strb.pc_in = 1'b1; strb.read = 1'b1; strb.mdr_in = 1'b1;
      end
      ST_T2: begin
        strb.mdr_out = 1'b1; strb.ir_in = 1'b1;
      end
      ST_T3: begin
        unique case (op_class)
          CLS_REG_ALU, CLS_IMM_ALU: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
          CLS_UNARY:   begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; end
          CLS_JR:      begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
          // R15 as the link target is forced by the select/encode logic.
          CLS_JAL:     begin strb.pc_out = 1'b1; strb.r_in = 1'b1; end
          CLS_ILLEGAL: strb.illegal = 1'b1;
          default:     ;
        endcase
      end
      ST_T4: begin
        unique case (op_class)
          CLS_REG_ALU: begin strb.grc = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; end
          CLS_IMM_ALU: begin strb.c_out = 1'b1; strb.z_in = 1'b1; end
          CLS_UNARY:   begin strb.z_lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          CLS_JAL:     begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
          default:     ;
        endcase
      end
      ST_T5: begin
        strb.z_lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
      end
      default: ;
    endcase
    if (bus.stall) strb = '0;
  end

  assign bus.pc_out   = strb.pc_out;
  assign bus.pc_in    = strb.pc_in;
  assign bus.inc_pc   = strb.inc_pc;
  assign bus.mar_in   = strb.mar_in;
  assign bus.mdr_in   = strb.mdr_in;
  assign bus.mdr_out  = strb.mdr_out;
  assign bus.read     = strb.read;
  assign bus.ir_in    = strb.ir_in;
  assign bus.y_in     = strb.y_in;
  assign bus.z_in     = strb.z_in;
  assign bus.z_lo_out = strb.z_lo_out;
  assign bus.c_out    = strb.c_out;
  assign bus.gra      = strb.gra;
  assign bus.grb      = strb.grb;
  assign bus.grc      = strb.grc;
  assign bus.r_in     = strb.r_in;
  assign bus.r_out    = strb.r_out;
  assign bus.illegal  = strb.illegal;
  assign bus.ba_out   = 1'b0;
  assign bus.run      = (state_q != ST_HALT);
  assign bus.alu_op   = (state_q == ST_T3 || state_q == ST_T4 || state_q == ST_T5)
                        ? opcode_q : 5'b00000;

endmodule
